rob_recovery_ctrl: RTL and testbench
====================================

# rob_recovery_ctrl

Branch-mispredict recovery sequencer for the R10K-style ROB. On a flush request it walks the ROB backwards from the youngest entry to the entry just after the mispredicted branch. For each squashed entry it restores the architectural-to-physical mapping to the map table and returns the entry's newly allocated PRF to the free list. It holds dispatch stalled while walking and reports the new ROB tail when finished.

## Interface
Parameters:
- DEPTH, 64, ROB entries (power of two); IDX_W = $clog2(DEPTH)
- WALK_WIDTH, 2, entries undone per cycle
- ARCH_REGS, 64, architectural registers; AR_W = $clog2(ARCH_REGS)
- PHYS_REGS, 128, physical registers; PR_W = $clog2(PHYS_REGS)

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-low
- flush_req_i  in  1  one-cycle flush pulse from ROB
- flush_rob_idx_i  in  IDX_W  ROB index of the mispredicted branch; the branch itself is kept
- rob_tail_i  in  IDX_W  ROB tail (next free slot), sampled with flush_req_i
- rd_idx_o  out  IDX_W x WALK_WIDTH  ROB read addresses; lane 0 is the youngest
- rd_rd_wen_i  in  WALK_WIDTH  rd_wen of the entry read on each lane (combinational read)
- rd_rd_arch_i  in  AR_W x WALK_WIDTH  arch rd of the entry read
- rd_new_prf_i  in  PR_W x WALK_WIDTH  new PRF of the entry read
- rd_old_prf_i  in  PR_W x WALK_WIDTH  old PRF of the entry read
- restore_valid_o  out  WALK_WIDTH  map-table restore strobe
- restore_arch_o  out  AR_W x WALK_WIDTH  arch reg to restore
- restore_prf_o  out  PR_W x WALK_WIDTH  old PRF to write back into the map table
- free_valid_o  out  WALK_WIDTH  free-list return strobe
- free_prf_o  out  PR_W x WALK_WIDTH  new PRF returned to the free list
- busy_o  out  1  recovery in progress; stalls dispatch and commit
- done_o  out  1  one-cycle completion pulse
- new_tail_o  out  IDX_W  equals flush_rob_idx+1 mod DEPTH; valid while done_o is high
- err_o  out  1  sticky; set when flush_req_i arrives while busy_o is high

## Operation
- Operates as a three-state FSM: IDLE, WALK, DONE.
- Registers: state, ptr (IDX_W), remaining (IDX_W+1 bits), branch index, err.
- **IDLE**: on flush_req_i, capture the following, then go to WALK if remaining != 0, else DONE:
  - remaining = (rob_tail_i − flush_rob_idx_i − 1) mod DEPTH
  - ptr = rob_tail_i − 1 mod DEPTH
  - branch index
- Full ROB case: tail equals the branch index, which gives remaining = DEPTH−1.
- **WALK**:
  - Lane i reads rd_idx_o[i] = ptr − i mod DEPTH. Lane i is active when i < remaining.
  - restore_valid_o[i] = active & rd_rd_wen_i[i]. restore_arch_o and restore_prf_o are driven from rd_rd_arch_i and rd_old_prf_i.
  - free_valid_o[i] = active & rd_rd_wen_i[i], with free_prf_o = rd_new_prf_i.
  - Each cycle: ptr −= n and remaining −= n, where n = min(WALK_WIDTH, remaining). Go to DONE when remaining reaches 0.
  - Lanes are processed youngest-first, so older mappings win when the same arch reg appears more than once.
- **DONE**: done_o = 1, new_tail_o = branch+1 mod DEPTH, then go to IDLE.
- busy_o = (state != IDLE).
- flush_req_i while busy_o is high: ignored and sets err_o. The ROB guarantees this does not happen.
- In IDLE, rd_idx_o is 0 and all strobes are 0.

## Timing
- flush_req_i is sampled at clock edge T. busy_o goes high in cycle T+1.
- WALK occupies ceil(N/WALK_WIDTH) cycles starting at T+1, where N = remaining.
- DONE is the cycle after the last WALK cycle. For N = 0, DONE is T+1.
- busy_o stays high through the DONE cycle and goes low the following cycle.
- rd_idx_o is a function of registered state only. Restore and free outputs are combinational from the rd_* inputs in the same cycle.
- Reset value of every output is 0, with state IDLE.
- Asserting reset mid-walk aborts immediately and asynchronously; no further strobes and no done_o.
- Index arithmetic is modulo DEPTH. Wrap from 0 to DEPTH−1 must be seamless.

## Test plan
- **Zero-entry flush**: branch=2, tail=3 → T+1: DONE, done_o=1, new_tail_o=3, no strobes; busy_o low at T+2.
- **Basic walk (WALK_WIDTH=2)**: branch=2, tail=7.
  - Cycle 1: rd_idx 6,5 with both lanes restoring old_prf and freeing new_prf.
  - Cycle 2: rd_idx 4,3.
  - Cycle 3: done_o, new_tail_o=3.
- **Wrap-around**: branch=62, tail=1.
  - One WALK cycle: rd_idx 0,63.
  - Then done_o with new_tail_o=63.
- **Odd count with a non-writing entry**: branch=10, tail=14, entry 12 has rd_wen=0.
  - Cycle 1: lanes 13,12, with strobes on lane 0 only.
  - Cycle 2: lane 0 = 11, lane 1 inactive.
  - Then done_o with new_tail_o=11.
- **Full ROB**: branch=tail=20 → 63 entries.
  - 32 WALK cycles, the last with only lane 0 active.
  - done_o in cycle 33, new_tail_o=21.
- **Abort and overlap**:
  - Async reset asserted mid-walk → outputs 0 immediately, state IDLE.
  - flush_req_i during busy_o → ignored and err_o=1 until reset.

Source files
------------

// File: rtl/rob_recovery_ctrl.sv
// Branch-mispredict recovery walker: undoes squashed ROB entries youngest-first,
// restoring map-table entries and returning new PRFs to the free list.
module rob_recovery_ctrl #(
    parameter int DEPTH      = 64,
    parameter int WALK_WIDTH = 2,
    parameter int ARCH_REGS  = 64,
    parameter int PHYS_REGS  = 128,
    localparam int IDX_W     = $clog2(DEPTH),
    localparam int AR_W      = $clog2(ARCH_REGS),
    localparam int PR_W      = $clog2(PHYS_REGS)
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 flush_req_i,
    input  logic [IDX_W-1:0]                     flush_rob_idx_i,
    input  logic [IDX_W-1:0]                     rob_tail_i,
    output logic [WALK_WIDTH-1:0][IDX_W-1:0]     rd_idx_o,
    input  logic [WALK_WIDTH-1:0]                rd_rd_wen_i,
    input  logic [WALK_WIDTH-1:0][AR_W-1:0]      rd_rd_arch_i,
    input  logic [WALK_WIDTH-1:0][PR_W-1:0]      rd_new_prf_i,
    input  logic [WALK_WIDTH-1:0][PR_W-1:0]      rd_old_prf_i,
    output logic [WALK_WIDTH-1:0]                restore_valid_o,
    output logic [WALK_WIDTH-1:0][AR_W-1:0]      restore_arch_o,
    output logic [WALK_WIDTH-1:0][PR_W-1:0]      restore_prf_o,
    output logic [WALK_WIDTH-1:0]                free_valid_o,
    output logic [WALK_WIDTH-1:0][PR_W-1:0]      free_prf_o,
    output logic                                 busy_o,
    output logic                                 done_o,
    output logic [IDX_W-1:0]                     new_tail_o,
    output logic                                 err_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WALK,
        S_DONE
    } state_e;

    localparam logic [IDX_W-1:0] ONE = IDX_W'(1);
    localparam logic [IDX_W:0]   WW  = (IDX_W + 1)'(WALK_WIDTH);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W:0]     rem_q, rem_d;
    logic [IDX_W-1:0]   br_q, br_d;
    logic               err_q, err_d;

    logic [IDX_W-1:0]   rem_calc;
    logic [IDX_W:0]     n;
    logic [WALK_WIDTH-1:0] lane_act;

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        rem_d    = rem_q;
        br_d     = br_q;
        err_d    = err_q;
        // Full ROB (tail == branch) wraps naturally to DEPTH-1
        rem_calc = rob_tail_i - flush_rob_idx_i - ONE;
        n        = (rem_q > WW) ? WW : rem_q;
        if (flush_req_i && state_q != S_IDLE) begin
            err_d = 1'b1;
        end
        unique case (state_q)
            S_IDLE: begin
                if (flush_req_i) begin
                    rem_d   = {1'b0, rem_calc};
                    ptr_d   = rob_tail_i - ONE;
                    br_d    = flush_rob_idx_i;
                    state_d = (rem_calc == '0) ? S_DONE : S_WALK;
                end
            end
            S_WALK: begin
                ptr_d = ptr_q - n[IDX_W-1:0];
                rem_d = rem_q - n;
                if (rem_q == n) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            rem_q   <= '0;
            br_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            rem_q   <= rem_d;
            br_q    <= br_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        lane_act        = '0;
        rd_idx_o        = '0;
        restore_valid_o = '0;
        restore_arch_o  = '0;
        restore_prf_o   = '0;
        free_valid_o    = '0;
        free_prf_o      = '0;
        for (int i = 0; i < WALK_WIDTH; i++) begin
            if (state_q == S_WALK) begin
                rd_idx_o[i] = ptr_q - IDX_W'(i);
                lane_act[i] = (IDX_W + 1)'(i) < rem_q;
            end
            if (lane_act[i]) begin
                restore_valid_o[i] = rd_rd_wen_i[i];
                free_valid_o[i]    = rd_rd_wen_i[i];
                restore_arch_o[i]  = rd_rd_arch_i[i];
                restore_prf_o[i]   = rd_old_prf_i[i];
                free_prf_o[i]      = rd_new_prf_i[i];
            end
        end
    end

    assign busy_o     = (state_q != S_IDLE);
    assign done_o     = (state_q == S_DONE);
    assign new_tail_o = (state_q == S_DONE) ? br_q + ONE : '0;
    assign err_o      = err_q;

endmodule

// File: tb/tb_rob_recovery_ctrl.sv
// Directed bench for rob_recovery_ctrl with a small ROB contents model
// answering the combinational read lanes.
module tb_rob_recovery_ctrl;

    logic                 clk = 1'b0;
    logic                 reset = 1'b0;
    logic                 flush_req_i = 1'b0;
    logic [5:0]           flush_rob_idx_i = '0;
    logic [5:0]           rob_tail_i = '0;
    logic [1:0][5:0]      rd_idx_o;
    logic [1:0]           rd_rd_wen_i;
    logic [1:0][5:0]      rd_rd_arch_i;
    logic [1:0][6:0]      rd_new_prf_i;
    logic [1:0][6:0]      rd_old_prf_i;
    logic [1:0]           restore_valid_o;
    logic [1:0][5:0]      restore_arch_o;
    logic [1:0][6:0]      restore_prf_o;
    logic [1:0]           free_valid_o;
    logic [1:0][6:0]      free_prf_o;
    logic                 busy_o;
    logic                 done_o;
    logic [5:0]           new_tail_o;
    logic                 err_o;

    int checks = 0;
    int errors = 0;

    logic       rob_wen [64];
    logic [5:0] rob_arch[64];
    logic [6:0] rob_new [64];
    logic [6:0] rob_old [64];

    rob_recovery_ctrl dut (
        .clk(clk),
        .reset(reset),
        .flush_req_i(flush_req_i),
        .flush_rob_idx_i(flush_rob_idx_i),
        .rob_tail_i(rob_tail_i),
        .rd_idx_o(rd_idx_o),
        .rd_rd_wen_i(rd_rd_wen_i),
        .rd_rd_arch_i(rd_rd_arch_i),
        .rd_new_prf_i(rd_new_prf_i),
        .rd_old_prf_i(rd_old_prf_i),
        .restore_valid_o(restore_valid_o),
        .restore_arch_o(restore_arch_o),
        .restore_prf_o(restore_prf_o),
        .free_valid_o(free_valid_o),
        .free_prf_o(free_prf_o),
        .busy_o(busy_o),
        .done_o(done_o),
        .new_tail_o(new_tail_o),
        .err_o(err_o)
    );

    always #5 clk = ~clk;

    always_comb begin
        rd_rd_wen_i  = '0;
        rd_rd_arch_i = '0;
        rd_new_prf_i = '0;
        rd_old_prf_i = '0;
        for (int i = 0; i < 2; i++) begin
            rd_rd_wen_i[i]  = rob_wen[rd_idx_o[i]];
            rd_rd_arch_i[i] = rob_arch[rd_idx_o[i]];
            rd_new_prf_i[i] = rob_new[rd_idx_o[i]];
            rd_old_prf_i[i] = rob_old[rd_idx_o[i]];
        end
    end

    // Leaves the bench at the negedge of cycle T+1
    task automatic pulse(input logic [5:0] br, input logic [5:0] tl);
        @(negedge clk);
        flush_req_i     = 1'b1;
        flush_rob_idx_i = br;
        rob_tail_i      = tl;
        @(negedge clk);
        flush_req_i     = 1'b0;
    endtask

    task automatic test_reset;
        #1;
        checks++;
        if ({busy_o, done_o, err_o, new_tail_o, rd_idx_o,
             restore_valid_o, free_valid_o} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got busy=%0b done=%0b err=%0b tail=%0d",
                     busy_o, done_o, err_o, new_tail_o);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (busy_o !== 1'b0 || rd_idx_o !== '0) begin
            errors++;
            $display("FAIL idle_after_reset got busy=%0b idx=%h want 0",
                     busy_o, rd_idx_o);
        end
    endtask

    task automatic test_zero;
        pulse(6'd2, 6'd3);
        checks++;
        if (done_o !== 1'b1 || new_tail_o !== 6'd3 || busy_o !== 1'b1 ||
            restore_valid_o !== 2'b00 || free_valid_o !== 2'b00) begin
            errors++;
            $display("FAIL zero_done got done=%0b tail=%0d busy=%0b rv=%b want 1 3 1 00",
                     done_o, new_tail_o, busy_o, restore_valid_o);
        end
        @(negedge clk);
        checks++;
        if (busy_o !== 1'b0 || done_o !== 1'b0) begin
            errors++;
            $display("FAIL zero_idle got busy=%0b done=%0b want 0 0", busy_o, done_o);
        end
    endtask

    task automatic test_basic;
        pulse(6'd2, 6'd7);
        checks++;
        if (rd_idx_o[0] !== 6'd6 || rd_idx_o[1] !== 6'd5 ||
            restore_valid_o !== 2'b11 || free_valid_o !== 2'b11 ||
            restore_prf_o[0] !== 7'd6 || free_prf_o[0] !== 7'd70 ||
            restore_arch_o[1] !== 6'd5 || free_prf_o[1] !== 7'd69 ||
            busy_o !== 1'b1) begin
            errors++;
            $display("FAIL basic_c1 got idx=%0d,%0d rv=%b fv=%b rp0=%0d fp0=%0d want 6,5 11 11 6 70",
                     rd_idx_o[0], rd_idx_o[1], restore_valid_o, free_valid_o,
                     restore_prf_o[0], free_prf_o[0]);
        end
        @(negedge clk);
        checks++;
        if (rd_idx_o[0] !== 6'd4 || rd_idx_o[1] !== 6'd3 ||
            restore_valid_o !== 2'b11 || restore_prf_o[1] !== 7'd3) begin
            errors++;
            $display("FAIL basic_c2 got idx=%0d,%0d rv=%b want 4,3 11",
                     rd_idx_o[0], rd_idx_o[1], restore_valid_o);
        end
        @(negedge clk);
        checks++;
        if (done_o !== 1'b1 || new_tail_o !== 6'd3 || restore_valid_o !== 2'b00) begin
            errors++;
            $display("FAIL basic_done got done=%0b tail=%0d want 1 3", done_o, new_tail_o);
        end
        @(negedge clk);
    endtask

    task automatic test_wrap;
        pulse(6'd62, 6'd1);
        checks++;
        if (rd_idx_o[0] !== 6'd0 || rd_idx_o[1] !== 6'd63 ||
            restore_valid_o !== 2'b11 || free_prf_o[1] !== 7'd127) begin
            errors++;
            $display("FAIL wrap_walk got idx=%0d,%0d rv=%b want 0,63 11",
                     rd_idx_o[0], rd_idx_o[1], restore_valid_o);
        end
        @(negedge clk);
        checks++;
        if (done_o !== 1'b1 || new_tail_o !== 6'd63) begin
            errors++;
            $display("FAIL wrap_done got done=%0b tail=%0d want 1 63", done_o, new_tail_o);
        end
        @(negedge clk);
    endtask

    task automatic test_odd;
        rob_wen[12] = 1'b0;
        pulse(6'd10, 6'd14);
        checks++;
        if (rd_idx_o[0] !== 6'd13 || rd_idx_o[1] !== 6'd12 ||
            restore_valid_o !== 2'b01 || free_valid_o !== 2'b01) begin
            errors++;
            $display("FAIL odd_c1 got idx=%0d,%0d rv=%b fv=%b want 13,12 01 01",
                     rd_idx_o[0], rd_idx_o[1], restore_valid_o, free_valid_o);
        end
        @(negedge clk);
        checks++;
        if (rd_idx_o[0] !== 6'd11 || restore_valid_o !== 2'b01 ||
            free_valid_o !== 2'b01 || restore_arch_o[0] !== 6'd11) begin
            errors++;
            $display("FAIL odd_c2 got idx0=%0d rv=%b fv=%b want 11 01 01",
                     rd_idx_o[0], restore_valid_o, free_valid_o);
        end
        @(negedge clk);
        checks++;
        if (done_o !== 1'b1 || new_tail_o !== 6'd11) begin
            errors++;
            $display("FAIL odd_done got done=%0b tail=%0d want 1 11", done_o, new_tail_o);
        end
        @(negedge clk);
        rob_wen[12] = 1'b1;
    endtask

    task automatic test_full;
        logic [5:0] exp_idx;
        logic [1:0] exp_v;
        pulse(6'd20, 6'd20);
        for (int k = 0; k < 32; k++) begin
            exp_idx = 6'(19 - 2 * k);
            exp_v   = (k == 31) ? 2'b01 : 2'b11;
            checks++;
            if (rd_idx_o[0] !== exp_idx || restore_valid_o !== exp_v ||
                done_o !== 1'b0) begin
                errors++;
                $display("FAIL full_walk[%0d] got idx0=%0d rv=%b done=%0b want %0d %b 0",
                         k, rd_idx_o[0], restore_valid_o, done_o, exp_idx, exp_v);
            end
            @(negedge clk);
        end
        checks++;
        if (done_o !== 1'b1 || new_tail_o !== 6'd21) begin
            errors++;
            $display("FAIL full_done got done=%0b tail=%0d want 1 21", done_o, new_tail_o);
        end
        @(negedge clk);
    endtask

    task automatic test_abort;
        pulse(6'd2, 6'd7);
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (busy_o !== 1'b0 || restore_valid_o !== 2'b00 ||
            free_valid_o !== 2'b00 || rd_idx_o !== '0 || done_o !== 1'b0) begin
            errors++;
            $display("FAIL abort got busy=%0b rv=%b fv=%b idx=%h want all 0",
                     busy_o, restore_valid_o, free_valid_o, rd_idx_o);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (done_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle got done=%0b busy=%0b want 0 0", done_o, busy_o);
        end
    endtask

    task automatic test_overlap;
        pulse(6'd2, 6'd7);
        flush_req_i     = 1'b1;
        flush_rob_idx_i = 6'd40;
        rob_tail_i      = 6'd50;
        @(negedge clk);
        flush_req_i = 1'b0;
        checks++;
        if (err_o !== 1'b1 || rd_idx_o[0] !== 6'd4 || rd_idx_o[1] !== 6'd3) begin
            errors++;
            $display("FAIL overlap_err got err=%0b idx=%0d,%0d want 1 4,3",
                     err_o, rd_idx_o[0], rd_idx_o[1]);
        end
        @(negedge clk);
        checks++;
        if (done_o !== 1'b1 || new_tail_o !== 6'd3) begin
            errors++;
            $display("FAIL overlap_done got done=%0b tail=%0d want 1 3", done_o, new_tail_o);
        end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (err_o !== 1'b1 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL err_sticky got err=%0b busy=%0b want 1 0", err_o, busy_o);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (err_o !== 1'b0) begin
            errors++;
            $display("FAIL err_clear got %0b want 0", err_o);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            rob_wen[i]  = 1'b1;
            rob_arch[i] = 6'(i);
            rob_new[i]  = 7'(i + 64);
            rob_old[i]  = 7'(i);
        end
        test_reset();
        test_zero();
        test_basic();
        test_wrap();
        test_odd();
        test_full();
        test_abort();
        test_overlap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
